jvm_decode_alu: RTL and testbench

// - Bytecode decode + integer execute block for the stack-machine core; sits between fetch and the control FSM.
// - Combinationally decodes a JVM opcode into control flags.
// - Executes the decoded ALU/compare operation on two 32-bit stack operands with a registered, 1-cycle-latency result.

---
 rtl/jvm_decode_alu.sv | 133 +++++++++++++
 tb/tb_jvm_decode_alu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jvm_decode_alu.sv
// jvm_decode_alu: combinational JVM opcode decode plus registered 1-cycle integer ALU/compare.
// Define JVM_IDIV_EN to add idiv/irem (signed divide/remainder).
module jvm_decode_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  opcode,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        start,
  output logic [3:0]  aluop,
  output logic        isaluop,
  output logic        iscmp,
  output logic        isconstpush,
  output logic        isargpush,
  output logic        isgoto,
  output logic        islvaread,
  output logic        islvawrite,
  output logic        isldc,
  output logic [3:0]  cmptype,
  output logic [31:0] constval,
  output logic [7:0]  lvaindex,
  output logic [1:0]  argc,
  output logic [1:0]  stackargs,
  output logic        stackwb,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        cmp_taken,
  output logic        done
);
  logic signed [63:0] prod;
  logic [31:0] alu_lo, rhs;
  logic cmp_now;
  assign prod = $signed(operand_a) * $signed(operand_b);
`ifdef JVM_IDIV_EN
  logic signed [31:0] div_d, div_q, div_r;
  // A divisor of 1 sidesteps both divide-by-zero and the MIN/-1 overflow.
  assign div_d = (operand_b == '0 || (operand_a == 32'h8000_0000 && operand_b == '1)) ? 32'sd1 : $signed(operand_b);
  assign div_q = (operand_b == '0) ? '0 : $signed(operand_a) / div_d;
  assign div_r = (operand_b == '0) ? '0 : $signed(operand_a) % div_d;
`endif
  always_comb begin
    aluop = '0;
    isaluop = 1'b0;
    iscmp = 1'b0;
    isconstpush = 1'b0;
    isargpush = 1'b0;
    isgoto = 1'b0;
    islvaread = 1'b0;
    islvawrite = 1'b0;
    isldc = 1'b0;
    cmptype = '0;
    constval = '0;
    lvaindex = '0;
    argc = '0;
    stackargs = '0;
    stackwb = 1'b0;
    case (opcode) inside
      [8'h02:8'h08]: begin isconstpush = 1'b1; constval = {24'b0, opcode} - 32'd3; stackwb = 1'b1; end
      8'h10, 8'h11:  begin isargpush = 1'b1; argc = opcode[0] ? 2'd2 : 2'd1; stackwb = 1'b1; end
      8'h12:         begin isldc = 1'b1; argc = 2'd1; stackwb = 1'b1; end
      8'h15:         begin islvaread = 1'b1; argc = 2'd1; stackwb = 1'b1; end
      [8'h1a:8'h1d]: begin islvaread = 1'b1; lvaindex = {6'b0, opcode[1:0] - 2'd2}; stackwb = 1'b1; end
      8'h36:         begin islvawrite = 1'b1; argc = 2'd1; stackargs = 2'd1; end
      [8'h3b:8'h3e]: begin islvawrite = 1'b1; lvaindex = {6'b0, opcode[1:0] + 2'd1}; stackargs = 2'd1; end
      8'h60:         begin isaluop = 1'b1; aluop = 4'd0; end
      8'h64:         begin isaluop = 1'b1; aluop = 4'd1; end
      8'h68:         begin isaluop = 1'b1; aluop = 4'd2; end
      8'h74:         begin isaluop = 1'b1; aluop = 4'd3; end
      8'h78:         begin isaluop = 1'b1; aluop = 4'd4; end
      8'h7a:         begin isaluop = 1'b1; aluop = 4'd5; end
      8'h7c:         begin isaluop = 1'b1; aluop = 4'd6; end
      8'h7e:         begin isaluop = 1'b1; aluop = 4'd7; end
      8'h80:         begin isaluop = 1'b1; aluop = 4'd8; end
      8'h82:         begin isaluop = 1'b1; aluop = 4'd9; end
`ifdef JVM_IDIV_EN
      8'h6c:         begin isaluop = 1'b1; aluop = 4'd10; end
      8'h70:         begin isaluop = 1'b1; aluop = 4'd11; end
`endif
      [8'h99:8'h9e]: begin iscmp = 1'b1; cmptype = {1'b0, 3'(opcode - 8'h99)}; argc = 2'd2; stackargs = 2'd1; end
      [8'h9f:8'ha4]: begin iscmp = 1'b1; cmptype = {1'b1, 3'(opcode - 8'h9f)}; argc = 2'd2; stackargs = 2'd2; end
      8'ha7:         begin isgoto = 1'b1; argc = 2'd2; end
      default: ;
    endcase
    if (isaluop) begin
      stackwb = 1'b1;
      stackargs = (opcode == 8'h74) ? 2'd1 : 2'd2;
    end
  end
  always_comb begin
    alu_lo = '0;
    case (aluop)
      4'd0: alu_lo = operand_a + operand_b;
      4'd1: alu_lo = operand_a - operand_b;
      4'd2: alu_lo = prod[31:0];
      4'd3: alu_lo = -operand_a;
      4'd4: alu_lo = operand_a << operand_b[4:0];
      4'd5: alu_lo = $signed(operand_a) >>> operand_b[4:0];
      4'd6: alu_lo = operand_a >> operand_b[4:0];
      4'd7: alu_lo = operand_a & operand_b;
      4'd8: alu_lo = operand_a | operand_b;
      4'd9: alu_lo = operand_a ^ operand_b;
`ifdef JVM_IDIV_EN
      4'd10: alu_lo = div_q;
      4'd11: alu_lo = div_r;
`endif
      default: ;
    endcase
    rhs = cmptype[3] ? operand_b : '0;
    case (cmptype[2:0])
      3'd0: cmp_now = operand_a == rhs;
      3'd1: cmp_now = operand_a != rhs;
      3'd2: cmp_now = $signed(operand_a) < $signed(rhs);
      3'd3: cmp_now = $signed(operand_a) >= $signed(rhs);
      3'd4: cmp_now = $signed(operand_a) > $signed(rhs);
      3'd5: cmp_now = $signed(operand_a) <= $signed(rhs);
      default: cmp_now = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      result_lo <= '0;
      result_hi <= '0;
      cmp_taken <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        result_lo <= isaluop ? alu_lo : '0;
        result_hi <= (isaluop && aluop == 4'd2) ? prod[63:32] : '0;
        cmp_taken <= iscmp & cmp_now;
      end
    end
endmodule

// File: tb/tb_jvm_decode_alu.sv
// tb_jvm_decode_alu: randomized scoreboard bench for jvm_decode_alu.
module tb_jvm_decode_alu;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [7:0] opcode = '0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic [3:0] aluop, cmptype;
  logic isaluop, iscmp, isconstpush, isargpush, isgoto, islvaread, islvawrite, isldc, stackwb;
  logic [31:0] constval, result_lo, result_hi;
  logic [7:0] lvaindex;
  logic [1:0] argc, stackargs;
  logic cmp_taken, done;

  typedef struct packed {logic [31:0] lo, hi; logic c;} res_t;
  typedef struct packed {
    logic alu, cmp, cp, ap, gt, lr, lw, ldc;
    logic [1:0] argc, sargs;
    logic wb;
    logic [3:0] aluop, ctype;
    logic [7:0] lva;
    logic [31:0] cval;
  } dec_t;

`ifdef JVM_IDIV_EN
  localparam int NALU = 12;
`else
  localparam int NALU = 10;
`endif
  logic [7:0] alu_ops [12] = '{8'h60, 8'h64, 8'h68, 8'h74, 8'h78, 8'h7a, 8'h7c, 8'h7e, 8'h80, 8'h82, 8'h6c, 8'h70};
  logic [7:0] pool [24] = '{8'h60, 8'h64, 8'h68, 8'h74, 8'h78, 8'h7a, 8'h7c, 8'h7e, 8'h80, 8'h82, 8'h6c, 8'h70,
                            8'h99, 8'h9a, 8'h9b, 8'h9c, 8'h9d, 8'h9e, 8'h9f, 8'ha0, 8'ha1, 8'ha2, 8'ha3, 8'ha4};

  res_t q[$];
  res_t last = '0;
  int checks = 0, errors = 0;
  dec_t dut_dec;

  jvm_decode_alu dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .start(start), .aluop(aluop), .isaluop(isaluop), .iscmp(iscmp), .isconstpush(isconstpush),
    .isargpush(isargpush), .isgoto(isgoto), .islvaread(islvaread), .islvawrite(islvawrite),
    .isldc(isldc), .cmptype(cmptype), .constval(constval), .lvaindex(lvaindex), .argc(argc),
    .stackargs(stackargs), .stackwb(stackwb), .result_lo(result_lo), .result_hi(result_hi),
    .cmp_taken(cmp_taken), .done(done)
  );

  assign dut_dec = {isaluop, iscmp, isconstpush, isargpush, isgoto, islvaread, islvawrite, isldc,
                    argc, stackargs, stackwb, aluop, cmptype, lvaindex, constval};

  always #5 clk = ~clk;

  function automatic res_t model(logic [7:0] op, logic [31:0] a, logic [31:0] b);
    res_t r;
    int sa, sb, rhs, k;
    longint p;
    r = '0;
    sa = a;
    sb = b;
    p = longint'(sa) * longint'(sb);
    case (op)
      8'h60: r.lo = a + b;
      8'h64: r.lo = a - b;
      8'h68: begin r.lo = p[31:0]; r.hi = p[63:32]; end
      8'h74: r.lo = 32'd0 - a;
      8'h78: r.lo = a << b[4:0];
      8'h7a: r.lo = sa >>> b[4:0];
      8'h7c: r.lo = a >> b[4:0];
      8'h7e: r.lo = a & b;
      8'h80: r.lo = a | b;
      8'h82: r.lo = a ^ b;
`ifdef JVM_IDIV_EN
      8'h6c: r.lo = (sb == 0) ? 32'd0 : (a == 32'h8000_0000 && sb == -1) ? a : 32'(sa / sb);
      8'h70: r.lo = (sb == 0) ? 32'd0 : (a == 32'h8000_0000 && sb == -1) ? 32'd0 : 32'(sa % sb);
`endif
      default:
        if (op >= 8'h99 && op <= 8'ha4) begin
          rhs = (op >= 8'h9f) ? sb : 0;
          k = (op >= 8'h9f) ? int'(op) - 'h9f : int'(op) - 'h99;
          case (k)
            0: r.c = sa == rhs;
            1: r.c = sa != rhs;
            2: r.c = sa < rhs;
            3: r.c = sa >= rhs;
            4: r.c = sa > rhs;
            default: r.c = sa <= rhs;
          endcase
        end
    endcase
    return r;
  endfunction

  function automatic dec_t dec_model(logic [7:0] op);
    dec_t d;
    d = '0;
    for (int i = 0; i < NALU; i++)
      if (op == alu_ops[i]) begin
        d.alu = 1'b1;
        d.aluop = 4'(i);
        d.sargs = (i == 3) ? 2'd1 : 2'd2;
        d.wb = 1'b1;
      end
    if (op >= 8'h02 && op <= 8'h08) begin d.cp = 1'b1; d.cval = 32'(int'(op) - 3); d.wb = 1'b1; end
    if (op == 8'h10 || op == 8'h11) begin d.ap = 1'b1; d.argc = (op == 8'h10) ? 2'd1 : 2'd2; d.wb = 1'b1; end
    if (op == 8'h12) begin d.ldc = 1'b1; d.argc = 2'd1; d.wb = 1'b1; end
    if (op == 8'h15) begin d.lr = 1'b1; d.argc = 2'd1; d.wb = 1'b1; end
    if (op >= 8'h1a && op <= 8'h1d) begin d.lr = 1'b1; d.lva = op - 8'h1a; d.wb = 1'b1; end
    if (op == 8'h36) begin d.lw = 1'b1; d.argc = 2'd1; d.sargs = 2'd1; end
    if (op >= 8'h3b && op <= 8'h3e) begin d.lw = 1'b1; d.lva = op - 8'h3b; d.sargs = 2'd1; end
    if (op >= 8'h99 && op <= 8'ha4) begin
      d.cmp = 1'b1;
      d.argc = 2'd2;
      d.sargs = (op >= 8'h9f) ? 2'd2 : 2'd1;
      d.ctype = (op >= 8'h9f) ? {1'b1, 3'(op - 8'h9f)} : {1'b0, 3'(op - 8'h99)};
    end
    if (op == 8'ha7) begin d.gt = 1'b1; d.argc = 2'd2; end
    return d;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hffff_ffff;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input logic st);
    dec_t e;
    @(negedge clk);
    opcode = op;
    operand_a = a;
    operand_b = b;
    start = st;
    if (st) q.push_back(model(op, a, b));
    #1;
    e = dec_model(op);
    checks++;
    if (dut_dec !== e) begin
      errors++;
      $display("FAIL decode op=%02h got=%h expected=%h", op, dut_dec, e);
    end
  endtask

  initial begin
    res_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (done) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL spurious_done got done=1 expected done=0");
          end else begin
            e = q.pop_front();
            last = e;
            if ({result_lo, result_hi, cmp_taken} !== e) begin
              errors++;
              $display("FAIL result got lo=%h hi=%h c=%b expected lo=%h hi=%h c=%b",
                       result_lo, result_hi, cmp_taken, e.lo, e.hi, e.c);
            end
          end
        end else begin
          checks++;
          if ({result_lo, result_hi, cmp_taken} !== last) begin
            errors++;
            $display("FAIL hold got lo=%h hi=%h c=%b expected lo=%h hi=%h c=%b",
                     result_lo, result_hi, cmp_taken, last.lo, last.hi, last.c);
          end
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({done, result_lo, result_hi, cmp_taken} !== '0) begin
      errors++;
      $display("FAIL reset_state got done=%b lo=%h hi=%h c=%b expected all 0", done, result_lo, result_hi, cmp_taken);
    end
    rst_n = 1'b1;
    issue(8'h60, 32'd7, 32'd5, 1'b1);
    issue(8'h00, 32'd0, 32'd0, 1'b0);
    issue(8'h68, 32'hffff_ffff, 32'd2, 1'b1);
    issue(8'h7a, 32'h8000_0000, 32'd33, 1'b1);
    issue(8'h7c, 32'h8000_0000, 32'd33, 1'b1);
    issue(8'h74, 32'h8000_0000, 32'd0, 1'b1);
    issue(8'ha1, 32'hffff_ffff, 32'd1, 1'b1);
    issue(8'h9a, 32'd0, 32'd9, 1'b1);
    issue(8'h12, 32'd3, 32'd4, 1'b1);
    issue(8'h02, 32'd0, 32'd0, 1'b0);
    issue(8'h11, 32'd0, 32'd0, 1'b0);
    issue(8'h3d, 32'd0, 32'd0, 1'b0);
    issue(8'ha7, 32'd0, 32'd0, 1'b0);
    issue(8'hff, 32'd0, 32'd0, 1'b0);
    issue(8'h6c, 32'hffff_fff9, 32'd2, 1'b1);
    issue(8'h70, 32'hffff_fff9, 32'd2, 1'b1);
    issue(8'h6c, 32'hffff_fff9, 32'd0, 1'b1);
    issue(8'h6c, 32'h8000_0000, 32'hffff_ffff, 1'b1);
    issue(8'h70, 32'h8000_0000, 32'hffff_ffff, 1'b1);
    for (int i = 0; i < 256; i++) issue(8'(i), pick(), pick(), 1'b0);
    for (int i = 0; i < 600; i++)
      issue(($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 23)] : 8'($urandom),
            pick(), pick(), $urandom_range(0, 3) != 0);
    issue(8'h00, 32'd0, 32'd0, 1'b0);
    issue(8'h60, 32'd7, 32'd5, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    last = '0;
    #1;
    checks++;
    if ({done, result_lo, result_hi, cmp_taken} !== '0) begin
      errors++;
      $display("FAIL async_reset got done=%b lo=%h hi=%h c=%b expected all 0", done, result_lo, result_hi, cmp_taken);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    issue(8'h64, 32'd9, 32'd4, 1'b1);
    @(negedge clk);
    opcode = 8'h60;
    operand_a = 32'd1;
    operand_b = 32'd2;
    start = 1'b1;
    #2 rst_n = 1'b0;
    last = '0;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending got %0d outstanding results expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
